muldiv_seq_ctrl: RTL and testbench
==================================

Name: muldiv_seq_ctrl

Overview:
- Sequences the iterative multiply/divide unit that sits beside the ALU in the Execute stage.
- Accepts an M-extension op from E and starts the unit.
- Holds F/D/E and bubbles M for the op's latency, then releases the result for one E-stage cycle.
- Its stall and bubble outputs feed the pipeline register enables alongside the forwarding/hazard logic.

Parameters:
- MUL_CYCLES, 2, iteration cycles for MUL* ops (>=1)
- DIV_CYCLES, 32, iteration cycles for DIV*/REM* ops (>=1)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- op_valid_E  input  1  instruction in E is an M-extension op
- op_is_div_E  input  1  1 = DIV/DIVU/REM/REMU, 0 = MUL*
- div_zero_E  input  1  divisor operand in E is zero (valid with op_valid_E)
- kill  input  1  trap/redirect kills instruction in E
- hold_ext  input  1  external pipeline hold (e.g. memory wait) from elsewhere
- start  output  1  unit captures operands and begins iterating
- unit_is_div  output  1  registered op type of accepted op, selects unit result mux
- iter_cnt  output  CNT_W  remaining iterations (debug/visibility)
- stall_FDE  output  1  hold F, D and E pipeline registers
- bubble_M  output  1  inject NOP into E/M register
- result_valid  output  1  unit result is valid on the E result bus this cycle
- abort  output  1  in-flight op discarded by kill

Behaviour:
- States: IDLE, RUN, DONE.
- Reset:
  - rst low forces state=IDLE, iter_cnt=0, unit_is_div=0 asynchronously.
  - While rst low, every output is 0, including combinational ones.
  - Reset mid-op abandons the op silently; abort is not raised.
- accept = state IDLE & op_valid_E & !kill.
- IDLE:
  - On accept: start=1 (combinational, same cycle); unit_is_div<=op_is_div_E.
  - If op_is_div_E & div_zero_E: fast path, next state DONE, iter_cnt<=0.
  - Otherwise next state RUN, iter_cnt<=(DIV_CYCLES-1 or MUL_CYCLES-1).
- RUN:
  - If iter_cnt!=0: iter_cnt<=iter_cnt-1.
  - If iter_cnt==0: next state DONE.
  - RUN lasts exactly N cycles, where N = MUL_CYCLES or DIV_CYCLES.
- DONE:
  - result_valid=1.
  - Next state IDLE unless hold_ext=1, in which case stay in DONE (result held stable).
- stall_FDE = accept | (state==RUN); bubble_M = stall_FDE.
- Stall is not asserted in DONE, so the op leaves E on the DONE edge (subject to hold_ext).
- Latency, normal op: accept cycle + N RUN cycles stalled; result_valid in cycle N+2 after accept.
- Latency, div-by-zero: 1 stall cycle; DONE in the next cycle.
- No re-accept in DONE: op_valid_E is still high for the same instruction, and DONE always exits to IDLE.
- kill:
  - In RUN or DONE: abort=1 (combinational), next state IDLE, stall_FDE=0 and result_valid=0 in that cycle.
  - In IDLE: blocks accept, abort=0.
  - kill has priority over hold_ext and over counter expiry.
- hold_ext in IDLE or RUN has no effect on sequencing; counting continues and stall is ORed externally.
- start is high only on accept cycles, never in RUN/DONE.
- iter_cnt never wraps: it is only decremented when nonzero.

Test Plan:
- MUL, defaults: op_valid_E=1, op_is_div_E=0 in one cycle → start=1 for 1 cycle; stall_FDE=bubble_M=1 for 3 cycles (iter_cnt 1,0 in RUN); result_valid=1 in cycle 4; idle afterwards.
- DIV, DIV_CYCLES=32: stall_FDE high 33 cycles; iter_cnt 31→0; unit_is_div=1; result_valid exactly 1 cycle at cycle 34; back-to-back second DIV accepted the cycle after DONE.
- Div-by-zero: op_is_div_E=1, div_zero_E=1 → start=1 and stall 1 cycle; result_valid next cycle; iter_cnt stays 0.
- Kill mid-DIV: kill pulsed when iter_cnt=10 → abort=1 and stall_FDE=0 that cycle; state IDLE next cycle; no result_valid; kill concurrent with new op in IDLE → no start.
- hold_ext in DONE for 3 cycles → result_valid high 4 consecutive cycles, no start, then IDLE; kill during held DONE → abort=1, IDLE next cycle.
- Reset mid-RUN: rst low at iter_cnt=5 → all outputs 0 immediately (asynchronous); after release, IDLE with iter_cnt=0 and no abort.

Source files
------------

// File: rtl/muldiv_seq_ctrl_if.sv
// Handshake bundle between the Execute-stage pipeline control and the
// multiply/divide sequencer.
//   master : pipeline side; drives the op description, kill and hold_ext.
//   slave  : sequencer side; returns start/type/count, stall/bubble and
//            result/abort strobes.
interface muldiv_seq_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             op_valid_E;
  logic             op_is_div_E;
  logic             div_zero_E;
  logic             kill;
  logic             hold_ext;
  logic             start;
  logic             unit_is_div;
  logic [CNT_W-1:0] iter_cnt;
  logic             stall_FDE;
  logic             bubble_M;
  logic             result_valid;
  logic             abort;

  modport master (
    output op_valid_E, op_is_div_E, div_zero_E, kill, hold_ext,
    input  start, unit_is_div, iter_cnt, stall_FDE, bubble_M, result_valid, abort
  );

  modport slave (
    input  op_valid_E, op_is_div_E, div_zero_E, kill, hold_ext,
    output start, unit_is_div, iter_cnt, stall_FDE, bubble_M, result_valid, abort
  );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative mul/div unit beside the Execute-stage ALU.
// Accepts an M-extension op in E, starts the unit, stalls F/D/E and bubbles
// M while the unit iterates, then presents the result for one E cycle
// (longer if the pipeline is held externally).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : muldiv_seq_ctrl_if slave (op in, start/stall/bubble/result out)
module muldiv_seq_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             is_div, is_div_n;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      is_div <= is_div_n;
    end
  end

  // Combinational outputs are qualified with rst so everything reads 0
  // while reset is held, even if the op inputs are active.
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    is_div_n         = is_div;
    accept           = 1'b0;
    bus.start        = 1'b0;
    bus.stall_FDE    = 1'b0;
    bus.result_valid = 1'b0;
    bus.abort        = 1'b0;
    unique case (state)
      IDLE: begin
        accept = rst && bus.op_valid_E && !bus.kill;
        if (accept) begin
          bus.start = 1'b1;
          is_div_n  = bus.op_is_div_E;
          if (bus.op_is_div_E && bus.div_zero_E) begin
            // Divide by zero has a fixed architectural result; skip iterating.
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            state_n = RUN;
            cnt_n   = bus.op_is_div_E ? DIV_LAST : MUL_LAST;
          end
        end
      end
      RUN: begin
        if (bus.kill) begin
          bus.abort = rst;
          state_n   = IDLE;
          cnt_n     = '0;
        end else begin
          bus.stall_FDE = rst;
          if (cnt == '0) state_n = DONE;
          else           cnt_n   = cnt - 1'b1;
        end
      end
      DONE: begin
        // No re-accept here: op_valid_E still reflects the finishing op.
        if (bus.kill) begin
          bus.abort = rst;
          state_n   = IDLE;
        end else begin
          bus.result_valid = rst;
          if (!bus.hold_ext) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept) bus.stall_FDE = 1'b1;
  end

  assign bus.bubble_M    = bus.stall_FDE;
  assign bus.unit_is_div = is_div;
  assign bus.iter_cnt    = cnt;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl with default parameters
// (MUL_CYCLES=2, DIV_CYCLES=32, CNT_W=6). Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns later, mid-cycle.
module tb_muldiv_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  muldiv_seq_ctrl_if #(.CNT_W(6)) bus ();

  muldiv_seq_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic d, input logic z, input logic k, input logic h);
    bus.op_valid_E  = v;
    bus.op_is_div_E = d;
    bus.div_zero_E  = z;
    bus.kill        = k;
    bus.hold_ext    = h;
    #1;
  endtask

  // start, stall, bubble, result_valid, abort in one shot
  task automatic chk_o(input string tag, input logic s, input logic st, input logic rv, input logic ab);
    chk({tag, ".start"}, 32'(bus.start), 32'(s));
    chk({tag, ".stall"}, 32'(bus.stall_FDE), 32'(st));
    chk({tag, ".bubble"}, 32'(bus.bubble_M), 32'(st));
    chk({tag, ".rv"}, 32'(bus.result_valid), 32'(rv));
    chk({tag, ".abort"}, 32'(bus.abort), 32'(ab));
  endtask

  // Run a MUL from accept up to its first DONE cycle (op still in E).
  task automatic mul_to_done(input logic h);
    drv(1, 0, 0, 0, 0);
    tick(); tick(); tick();
    drv(1, 0, 0, 0, h);
  endtask

  initial begin
    int guard;
    int stalls;
    drv(1, 1, 0, 0, 0);
    // Reset held with an op present: everything must read 0.
    chk_o("rst", 0, 0, 0, 0);
    chk("rst.cnt", 32'(bus.iter_cnt), 0);
    chk("rst.isdiv", 32'(bus.unit_is_div), 0);
    drv(0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk_o("idle", 0, 0, 0, 0);

    // ---- MUL ----
    drv(1, 0, 0, 0, 0);
    chk_o("mul.c1", 1, 1, 0, 0);
    tick(); drv(1, 0, 0, 0, 0);
    chk_o("mul.c2", 0, 1, 0, 0);
    chk("mul.c2.cnt", 32'(bus.iter_cnt), 1);
    chk("mul.isdiv", 32'(bus.unit_is_div), 0);
    tick(); drv(1, 0, 0, 0, 0);
    chk_o("mul.c3", 0, 1, 0, 0);
    chk("mul.c3.cnt", 32'(bus.iter_cnt), 0);
    tick(); drv(1, 0, 0, 0, 0);
    chk_o("mul.c4", 0, 0, 1, 0);
    tick(); drv(0, 0, 0, 0, 0);
    chk_o("mul.c5", 0, 0, 0, 0);

    // ---- DIV, full length ----
    drv(1, 1, 0, 0, 0);
    chk_o("div.acc", 1, 1, 0, 0);
    stalls = 1;
    for (int i = 0; i < 32; i++) begin
      tick(); drv(1, 1, 0, 0, 0);
      if (bus.stall_FDE) stalls++;
      chk($sformatf("div.cnt%0d", i), 32'(bus.iter_cnt), 32'(31 - i));
      chk($sformatf("div.st%0d", i), {bus.start, bus.result_valid}, 2'b00);
    end
    chk("div.stalls", 32'(stalls), 33);
    chk("div.isdiv", 32'(bus.unit_is_div), 1);
    tick(); drv(1, 1, 0, 0, 0);
    chk_o("div.done", 0, 0, 1, 0);
    // Back-to-back DIV accepted in the cycle after DONE.
    tick(); drv(1, 1, 0, 0, 0);
    chk_o("div2.acc", 1, 1, 0, 0);

    // ---- kill mid-DIV at iter_cnt==10 ----
    guard = 0;
    do begin
      tick(); drv(1, 1, 0, 0, 0); guard++;
    end while (bus.iter_cnt != 10 && guard < 60);
    chk("kill.reach", 32'(guard), 22);
    drv(1, 1, 0, 1, 0);
    chk_o("kill.run", 0, 0, 0, 1);
    tick(); drv(0, 0, 0, 0, 0);
    chk_o("kill.idle", 0, 0, 0, 0);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); drv(0, 0, 0, 0, 0);
      if (bus.result_valid || bus.stall_FDE) stalls++;
    end
    chk("kill.quiet", 32'(stalls), 0);
    // kill alongside a new op in IDLE blocks accept
    drv(1, 0, 0, 1, 0);
    chk_o("kill.idleop", 0, 0, 0, 0);
    tick(); drv(0, 0, 0, 0, 0);
    chk_o("kill.noacc", 0, 0, 0, 0);

    // ---- divide by zero ----
    drv(1, 1, 1, 0, 0);
    chk_o("dz.acc", 1, 1, 0, 0);
    tick(); drv(1, 1, 1, 0, 0);
    chk_o("dz.done", 0, 0, 1, 0);
    chk("dz.cnt", 32'(bus.iter_cnt), 0);
    chk("dz.isdiv", 32'(bus.unit_is_div), 1);
    tick(); drv(0, 0, 0, 0, 0);
    chk_o("dz.idle", 0, 0, 0, 0);

    // ---- hold_ext in DONE for 3 cycles ----
    mul_to_done(1);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 0, (i < 3));
      chk_o($sformatf("hold.d%0d", i), 0, 0, 1, 0);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    chk_o("hold.idle", 0, 0, 0, 0);

    // ---- kill during held DONE ----
    mul_to_done(1);
    chk_o("hk.done", 0, 0, 1, 0);
    tick(); drv(1, 0, 0, 1, 1);
    chk_o("hk.kill", 0, 0, 0, 1);
    tick(); drv(0, 0, 0, 0, 0);
    chk_o("hk.idle", 0, 0, 0, 0);

    // ---- reset mid-RUN at iter_cnt==5 ----
    drv(1, 1, 0, 0, 0);
    guard = 0;
    do begin
      tick(); drv(1, 1, 0, 0, 0); guard++;
    end while (bus.iter_cnt != 5 && guard < 60);
    chk("rr.reach", 32'(guard), 27);
    rst = 1'b0;
    #1;
    chk_o("rr.low", 0, 0, 0, 0);
    chk("rr.cnt", 32'(bus.iter_cnt), 0);
    chk("rr.isdiv", 32'(bus.unit_is_div), 0);
    tick(); tick();
    drv(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_o("rr.idle", 0, 0, 0, 0);
    chk("rr.cnt2", 32'(bus.iter_cnt), 0);
    // Confirm the controller is idle (accepts a fresh op).
    drv(1, 0, 0, 0, 0);
    chk_o("rr.acc", 1, 1, 0, 0);
    tick(); drv(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
